// File: rtl/ucd_mux_ssd_pkg.sv
// Shared seven-segment constants and counter encodings for the SSD display blocks.
package ssd_pkg;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_BCD = 1'b1;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Largest legal nibble value for the active count mode
  function automatic logic [3:0] nib_max(input logic mode);
    return (mode == MODE_BCD) ? 4'd9 : 4'hF;
  endfunction

endpackage

// File: rtl/ucd_mux_ssd_if.sv
// Control/display bundle of the up/down SSD counter; master = board side, slave = counter.
interface ucd_mux_ssd_if #(
  parameter int DIGITS = 8
);
  logic              ucd_mux_ssd_en;
  logic              ucd_mux_ssd_mode;
  logic              ucd_mux_ssd_dir;
  logic              ucd_mux_ssd_clr;
  logic              ucd_mux_ssd_rst_led;
  logic              ucd_mux_ssd_en_led;
  logic              ucd_mux_ssd_mode_led;
  logic              ucd_mux_ssd_dir_led;
  logic              ucd_mux_ssd_wrap;
  logic [6:0]        ucd_mux_ssd_cc;
  logic [DIGITS-1:0] ucd_mux_ssd_an;

  modport master (
    output ucd_mux_ssd_en, ucd_mux_ssd_mode, ucd_mux_ssd_dir, ucd_mux_ssd_clr,
    input  ucd_mux_ssd_rst_led, ucd_mux_ssd_en_led, ucd_mux_ssd_mode_led,
           ucd_mux_ssd_dir_led, ucd_mux_ssd_wrap, ucd_mux_ssd_cc, ucd_mux_ssd_an
  );

  modport slave (
    input  ucd_mux_ssd_en, ucd_mux_ssd_mode, ucd_mux_ssd_dir, ucd_mux_ssd_clr,
    output ucd_mux_ssd_rst_led, ucd_mux_ssd_en_led, ucd_mux_ssd_mode_led,
           ucd_mux_ssd_dir_led, ucd_mux_ssd_wrap, ucd_mux_ssd_cc, ucd_mux_ssd_an
  );
endinterface

// File: rtl/ucd_mux_ssd_dec.sv
// ssd_hex_decoder: combinational nibble to active-low {g..a} cathode pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      default: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ucd_mux_ssd.sv
// Hex/BCD up/down counter driving a multiplexed seven-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the top nonzero nibble.
module ucd_mux_ssd
  import ssd_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 100000
) (
  input logic          ucd_mux_ssd_clk,
  input logic          ucd_mux_ssd_rst,
  ucd_mux_ssd_if.slave bus
);

  localparam int CW = 4 * DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]     r_count;
  logic [TW-1:0]     r_tick_div;
  logic [SW-1:0]     r_scan_div;
  logic [IW-1:0]     r_scan_idx;
  logic              r_mode;
  logic              r_wrap;
  logic [DIGITS-1:0] r_an_p1;
  logic [6:0]        r_cc_p1;

  logic              w_tick;
  logic              w_mode_chg;
  logic              w_scan_step;
  logic [3:0]        w_max;
  logic [DIGITS:0]   w_cy;
  logic [CW-1:0]     w_next;
  logic [3:0]        w_sel;
  logic              w_blank;
  logic [6:0]        w_seg;

  assign bus.ucd_mux_ssd_rst_led  = ucd_mux_ssd_rst;
  assign bus.ucd_mux_ssd_en_led   = bus.ucd_mux_ssd_en;
  assign bus.ucd_mux_ssd_mode_led = bus.ucd_mux_ssd_mode;
  assign bus.ucd_mux_ssd_dir_led  = bus.ucd_mux_ssd_dir;
  assign bus.ucd_mux_ssd_wrap     = r_wrap;
  assign bus.ucd_mux_ssd_cc       = r_cc_p1;
  assign bus.ucd_mux_ssd_an       = r_an_p1;

  assign w_tick      = bus.ucd_mux_ssd_en && (r_tick_div == TICK_LAST);
  assign w_mode_chg  = (bus.ucd_mux_ssd_mode != r_mode);
  assign w_scan_step = (r_scan_div == SCAN_LAST);
  assign w_max       = nib_max(r_mode);

  // Per-nibble ripple: a nibble steps when every lower nibble sits at its turn-over value
  assign w_cy[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    logic [3:0] w_nib;
    logic [3:0] w_step;
    logic       w_edge;
    assign w_nib  = r_count[4*g +: 4];
    assign w_edge = (bus.ucd_mux_ssd_dir == DIR_UP) ? (w_nib == w_max) : (w_nib == 4'd0);
    assign w_step = (bus.ucd_mux_ssd_dir == DIR_UP)
                  ? ((w_nib == w_max) ? 4'd0  : w_nib + 4'd1)
                  : ((w_nib == 4'd0)  ? w_max : w_nib - 4'd1);
    assign w_cy[g+1]          = w_cy[g] & w_edge;
    assign w_next[4*g +: 4]   = w_cy[g] ? w_step : w_nib;
  end

  always_comb begin
    w_sel   = 4'd0;
    w_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scan_idx == IW'(k)) begin
        w_sel = r_count[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (k != 0) && ((r_count >> (4*k)) == '0);
`else
        w_blank = 1'b0;
`endif
      end
    end
  end

  ssd_hex_decoder u_dec (
    .i_nib (w_sel),
    .o_seg (w_seg)
  );

  // Count datapath; mode is re-sampled during reset so release never looks like a change
  always_ff @(posedge ucd_mux_ssd_clk) begin
    if (ucd_mux_ssd_rst) begin
      r_count    <= '0;
      r_tick_div <= '0;
      r_wrap     <= 1'b0;
      r_mode     <= bus.ucd_mux_ssd_mode;
    end else begin
      r_mode <= bus.ucd_mux_ssd_mode;
      r_wrap <= 1'b0;
      if (bus.ucd_mux_ssd_clr || w_mode_chg) begin
        r_count <= '0;
      end else if (w_tick) begin
        r_count <= w_next;
        r_wrap  <= w_cy[DIGITS];
      end
      if (bus.ucd_mux_ssd_en) begin
        r_tick_div <= w_tick ? '0 : r_tick_div + 1'b1;
      end
    end
  end

  // Scan stage -> registered anode/cathode outputs (p1)
  always_ff @(posedge ucd_mux_ssd_clk) begin
    if (ucd_mux_ssd_rst) begin
      r_scan_div <= '0;
      r_scan_idx <= '0;
      r_an_p1    <= '1;
      r_cc_p1    <= SEG_BLANK;
    end else begin
      if (w_scan_step) begin
        r_scan_div <= '0;
        r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + 1'b1;
      end else begin
        r_scan_div <= r_scan_div + 1'b1;
      end
      r_an_p1 <= ~(DIGITS'(1) << r_scan_idx);
      r_cc_p1 <= w_blank ? SEG_BLANK : w_seg;
    end
  end

endmodule
